// File: rtl/cntr_n_burst_pkg.sv
// Shared state encoding, direction type and state-class helpers for the burst counter.
package cntr_n_burst_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_UP         = 3'd2,
    ST_UP_BURST   = 3'd3,
    ST_DOWN       = 3'd4,
    ST_DOWN_BURST = 3'd5
  } state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  function automatic logic is_up(input state_t s);
    return (s == ST_UP) || (s == ST_UP_BURST);
  endfunction

  function automatic logic is_down(input state_t s);
    return (s == ST_DOWN) || (s == ST_DOWN_BURST);
  endfunction

endpackage

// File: rtl/cntr_step_alu.sv
// Combinational add/subtract of one step with wrap or clamp, flagging any
// result that left the 0 .. 2^WIDTH-1 range.
module cntr_step_alu
  import cntr_n_burst_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic [WIDTH-1:0]  d_cur,
  input  logic [STEP_W:0]   step_eff,
  input  dir_t              dir,
  input  logic              sat,
  output logic [WIDTH-1:0]  d_next,
  output logic              limit
);

  logic [WIDTH:0] ext_cur;
  logic [WIDTH:0] ext_step;
  logic [WIDTH:0] res;

  // The extra top bit is the carry on an add and the borrow on a subtract.
  always_comb begin
    ext_cur  = {1'b0, d_cur};
    ext_step = (WIDTH+1)'(step_eff);
    if (dir == DIR_UP) begin
      res = ext_cur + ext_step;
    end else begin
      res = ext_cur - ext_step;
    end
    limit  = res[WIDTH];
    d_next = res[WIDTH-1:0];
    if (limit && sat) begin
      d_next = (dir == DIR_UP) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    end
  end

endmodule

// File: rtl/cntr_n_burst.sv
// Up/down counter with programmable step, burst (2x step) on sustained counting,
// wrap/saturate modes. Define CNTR_WRAP_CNT_EN to add the o_wrap_cnt wrap counter.
module cntr_n_burst
  import cntr_n_burst_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int STEP_W    = 4,
  parameter int BURST_LEN = 4,
  parameter int WRAP_CW   = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic                inc,
  input  logic                dec,
  input  logic                sat,
  input  logic [STEP_W-1:0]   step,
  input  logic [WIDTH-1:0]    d_in,
  output logic [WIDTH-1:0]    d_out,
  output logic [STATE_W-1:0]  o_state,
  output logic                o_tc_max,
  output logic                o_tc_min,
  output logic                o_limit
`ifdef CNTR_WRAP_CNT_EN
  ,
  output logic [WRAP_CW-1:0]  o_wrap_cnt
`endif
);

  localparam int RUN_W = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(BURST_LEN - 1);

  // Degenerate parameter sets leave this empty block as an elaboration marker.
  if (BURST_LEN < 2 || WRAP_CW < 1) begin : g_param_out_of_range
  end

  state_t            state_reg, state_next;
  logic [RUN_W-1:0]  run_cnt_reg, run_cnt_next;
  logic [WIDTH-1:0]  d_reg;
  logic              limit_reg;
  logic              cnt_en;
  logic              burst;
  dir_t              dir;
  logic [STEP_W:0]   step_eff;
  logic [WIDTH-1:0]  alu_next;
  logic              alu_limit;
  logic              state_legal;

  // run_cnt counts consecutive cycles in one direction, starting at 1 on entry.
  always_comb begin
    state_next   = ST_IDLE;
    run_cnt_next = '0;
    cnt_en       = 1'b0;
    burst        = 1'b0;
    dir          = DIR_UP;
    state_legal  = (state_reg inside {ST_IDLE, ST_LOAD, ST_UP, ST_UP_BURST,
                                      ST_DOWN, ST_DOWN_BURST});
    if (!state_legal) begin
      state_next = ST_IDLE;
    end else if (load) begin
      state_next = ST_LOAD;
    end else if (inc && !dec) begin
      cnt_en = 1'b1;
      dir    = DIR_UP;
      if (is_up(state_reg)) begin
        burst        = (run_cnt_reg >= RUN_MAX);
        run_cnt_next = burst ? RUN_MAX : run_cnt_reg + RUN_W'(1);
      end else begin
        run_cnt_next = RUN_W'(1);
      end
      state_next = burst ? ST_UP_BURST : ST_UP;
    end else if (dec && !inc) begin
      cnt_en = 1'b1;
      dir    = DIR_DOWN;
      if (is_down(state_reg)) begin
        burst        = (run_cnt_reg >= RUN_MAX);
        run_cnt_next = burst ? RUN_MAX : run_cnt_reg + RUN_W'(1);
      end else begin
        run_cnt_next = RUN_W'(1);
      end
      state_next = burst ? ST_DOWN_BURST : ST_DOWN;
    end
    step_eff = burst ? {step, 1'b0} : {1'b0, step};
  end

  cntr_step_alu #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_alu (
    .d_cur    (d_reg),
    .step_eff (step_eff),
    .dir      (dir),
    .sat      (sat),
    .d_next   (alu_next),
    .limit    (alu_limit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= ST_IDLE;
      run_cnt_reg <= '0;
      d_reg       <= '0;
      limit_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      run_cnt_reg <= run_cnt_next;
      limit_reg   <= cnt_en && alu_limit;
      if (state_next == ST_LOAD) begin
        d_reg <= d_in;
      end else if (cnt_en) begin
        d_reg <= alu_next;
      end
    end
  end

`ifdef CNTR_WRAP_CNT_EN
  logic [WRAP_CW-1:0] wrap_cnt_reg;

  // Only true wraps count; clamps in saturate mode leave the count alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrap_cnt_reg <= '0;
    end else if (state_next == ST_LOAD) begin
      wrap_cnt_reg <= '0;
    end else if (cnt_en && alu_limit && !sat) begin
      wrap_cnt_reg <= wrap_cnt_reg + WRAP_CW'(1);
    end
  end

  assign o_wrap_cnt = wrap_cnt_reg;
`endif

  assign d_out    = d_reg;
  assign o_state  = state_reg;
  assign o_limit  = limit_reg;
  assign o_tc_max = (d_reg == {WIDTH{1'b1}});
  assign o_tc_min = (d_reg == {WIDTH{1'b0}});

endmodule

// File: tb/tb_cntr_n_burst.sv
// Directed plus randomized bench for cntr_n_burst against an integer-arithmetic reference model.
module tb_cntr_n_burst;

  localparam int WIDTH     = 8;
  localparam int STEP_W    = 4;
  localparam int BURST_LEN = 4;
  localparam int WRAP_CW   = 8;
  localparam int MAXV      = (1 << WIDTH) - 1;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               load, inc, dec, sat;
  logic [STEP_W-1:0]  step;
  logic [WIDTH-1:0]   d_in;
  logic [WIDTH-1:0]   d_out;
  logic [2:0]         o_state;
  logic               o_tc_max, o_tc_min, o_limit;
`ifdef CNTR_WRAP_CNT_EN
  logic [WRAP_CW-1:0] o_wrap_cnt;
`endif

  cntr_n_burst #(
    .WIDTH     (WIDTH),
    .STEP_W    (STEP_W),
    .BURST_LEN (BURST_LEN),
    .WRAP_CW   (WRAP_CW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .inc      (inc),
    .dec      (dec),
    .sat      (sat),
    .step     (step),
    .d_in     (d_in),
    .d_out    (d_out),
    .o_state  (o_state),
    .o_tc_max (o_tc_max),
    .o_tc_min (o_tc_min),
    .o_limit  (o_limit)
`ifdef CNTR_WRAP_CNT_EN
    ,
    .o_wrap_cnt (o_wrap_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: value as an unbounded int, run length as a plain count.
  int m_val, m_state, m_run, m_dir, m_limit, m_wraps;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_val = 0; m_state = 0; m_run = 0; m_dir = 0; m_limit = 0; m_wraps = 0;
  endtask

  task automatic model_step();
    int d, nv, mult;
    bit burst;
    m_limit = 0;
    if (load) begin
      m_val = int'(d_in); m_state = 1; m_dir = 0; m_run = 0; m_wraps = 0;
    end else if (inc != dec) begin
      d       = inc ? 1 : -1;
      m_run   = (m_dir == d) ? m_run + 1 : 1;
      m_dir   = d;
      burst   = (m_run >= BURST_LEN);
      m_state = inc ? (burst ? 3 : 2) : (burst ? 5 : 4);
      mult    = burst ? 2 : 1;
      nv      = m_val + d * int'(step) * mult;
      if (nv > MAXV || nv < 0) begin
        m_limit = 1;
        if (sat) begin
          nv = (nv > MAXV) ? MAXV : 0;
        end else begin
          nv = (nv + 2 * (MAXV + 1)) % (MAXV + 1);
          m_wraps = (m_wraps + 1) % (1 << WRAP_CW);
        end
      end
      m_val = nv;
    end else begin
      m_state = 0; m_dir = 0; m_run = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".d_out"}, 32'(d_out), 32'(m_val));
    chk({tag, ".state"}, 32'(o_state), 32'(m_state));
    chk({tag, ".limit"}, 32'(o_limit), 32'(m_limit));
    chk({tag, ".tc_max"}, 32'(o_tc_max), 32'(m_val == MAXV));
    chk({tag, ".tc_min"}, 32'(o_tc_min), 32'(m_val == 0));
`ifdef CNTR_WRAP_CNT_EN
    chk({tag, ".wrap"}, 32'(o_wrap_cnt), 32'(m_wraps));
`endif
  endtask

  task automatic cyc(input logic l, input logic i, input logic dc, input logic s,
                     input logic [STEP_W-1:0] st, input logic [WIDTH-1:0] din,
                     input string tag);
    load = l; inc = i; dec = dc; sat = s; step = st; d_in = din;
    @(posedge clk);
    #1;
    model_step();
    check_all(tag);
  endtask

  initial begin
    logic [WIDTH-1:0] exp_up [6];
    logic [2:0]       exp_st [6];
    int               rdir;
    logic             ri, rd;
    exp_up = '{8'h10, 8'h11, 8'h12, 8'h14, 8'h16, 8'h18};
    exp_st = '{3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3};

    reset_n = 1'b0;
    load = 0; inc = 0; dec = 0; sat = 0; step = '0; d_in = '0;
    model_reset();
    #12;
    check_all("reset");
    chk("reset.tc_min_lit", 32'(o_tc_min), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // Load
    cyc(1, 0, 0, 0, 4'd0, 8'h0F, "load");
    chk("load.lit", 32'(d_out), 32'h0F);
    chk("load.state_lit", 32'(o_state), 32'd1);

    // Burst up: three UP steps then UP_BURST
    for (int k = 0; k < 6; k++) begin
      cyc(0, 1, 0, 0, 4'd1, 8'h00, "burst");
      chk("burst.lit", 32'(d_out), 32'(exp_up[k]));
      chk("burst.state_lit", 32'(o_state), 32'(exp_st[k]));
    end

    // Wrap up
    cyc(1, 0, 0, 0, 4'd0, 8'hFE, "wrap.load");
    cyc(0, 1, 0, 0, 4'd3, 8'h00, "wrap");
    chk("wrap.lit", 32'(d_out), 32'h01);
    chk("wrap.limit_lit", 32'(o_limit), 32'd1);
    cyc(0, 0, 0, 0, 4'd3, 8'h00, "wrap.idle");
    chk("wrap.pulse_end", 32'(o_limit), 32'd0);

    // Exact hit of max does not pulse limit
    cyc(1, 0, 0, 0, 4'd0, 8'hFC, "hit.load");
    cyc(0, 1, 0, 1, 4'd3, 8'h00, "hit");
    chk("hit.limit_lit", 32'(o_limit), 32'd0);

    // Saturate down
    cyc(1, 0, 0, 1, 4'd0, 8'h02, "sat.load");
    cyc(0, 0, 1, 1, 4'd5, 8'h00, "sat");
    chk("sat.lit", 32'(d_out), 32'h00);
    chk("sat.state_lit", 32'(o_state), 32'd4);
    cyc(0, 0, 1, 1, 4'd5, 8'h00, "sat2");
    chk("sat2.limit_lit", 32'(o_limit), 32'd1);

    // Conflict and priority
    cyc(0, 1, 1, 0, 4'd2, 8'h00, "conflict");
    chk("conflict.state_lit", 32'(o_state), 32'd0);
    cyc(1, 1, 0, 0, 4'd2, 8'hA5, "prio");
    chk("prio.lit", 32'(d_out), 32'hA5);
    cyc(0, 1, 0, 0, 4'd1, 8'h00, "prio.next");
    chk("prio.next_state_lit", 32'(o_state), 32'd2);

    // Async reset while in UP_BURST
    for (int k = 0; k < 5; k++) cyc(0, 1, 0, 0, 4'd1, 8'h00, "pre_rst");
    chk("pre_rst.state_lit", 32'(o_state), 32'd3);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    cyc(0, 1, 0, 0, 4'd1, 8'h00, "post_rst");
    chk("post_rst.state_lit", 32'(o_state), 32'd2);

    // Randomized run with direction persistence so bursts occur
    rdir = 1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 3) rdir = $urandom_range(0, 3);
      ri = (rdir == 1) || (rdir == 3);
      rd = (rdir == 2) || (rdir == 3);
      cyc(($urandom_range(0, 15) == 0), ri, rd, 1'($urandom_range(0, 1)),
          STEP_W'($urandom), WIDTH'($urandom), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
